dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that sits between the CPU execute stage and the word-organised data memory.
- Accepts byte, halfword and word loads/stores at byte addresses.
- Drives the memory's rd/wr/addr/wdata port with word-aligned addresses only; rdata is combinational.
- Sub-word stores are done as a read-modify-write sequence, because the memory has no byte enables.

Parameters:
- RAM_SIZE, 256: memory depth in 32-bit words. Byte addresses >= RAM_SIZE*4 are out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  LSU can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  completion flagged as an error (out-of-range, or misaligned when the option is built in).
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe; the memory commits the write at the clk edge.
- mem_addr  out  32  word-aligned byte address, bits [1:0] always 0.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data, valid in the same cycle as mem_rd.

Behaviour:
- Byte order is little-endian. The byte lane is addr[1:0]; the half lane is addr[1].
- Without the optional feature, low address bits below the access size are ignored.
- Reset state:
  - State = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_rd = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - req_ready = 0 while reset is high.
- IDLE:
  - req_ready = 1.
  - A handshake is req_valid & req_ready. On a handshake the LSU latches we, size, signed, addr and wdata.
  - Next state: out-of-range -> RESP (err); load -> LOAD; word store -> WRITE; sub-word store -> RMW_RD.
- LOAD:
  - mem_rd = 1.
  - Extract the lane from mem_rdata, extend it, and register it into resp_rdata.
  - Next state: RESP.
- RMW_RD:
  - mem_rd = 1.
  - Merge the store byte/half into mem_rdata and register the result as the merge word.
  - Next state: WRITE.
- WRITE:
  - mem_wr = 1.
  - mem_wdata = the merge word, or the latched wdata for a word store.
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next state: IDLE.
- Latency, with the handshake in cycle N:
  - Load and word store: mem strobe in N+1, resp_valid in N+2.
  - Sub-word store: read in N+1, write in N+2, resp_valid in N+3.
  - Error completion: resp_valid in N+1, with no memory strobe.
- mem_rd and mem_wr are never asserted in the same cycle.
- mem_addr and mem_wdata are 0 whenever no strobe is active.
- Request inputs are ignored outside IDLE; no queueing.
- Reset mid-operation: return to IDLE at the next edge.
  - A pending RMW write that has not yet been issued is dropped; no partial write reaches memory.
  - No resp_valid is produced for the aborted request.
- Out-of-range load: resp_rdata = 0, resp_err = 1.
- Out-of-range store: no write, resp_err = 1.

Optional Feature:
- Macro name: DMEM_LSU_MISALIGN_TRAP_EN.
- When defined: a half access with addr[0] != 0, or a word access with addr[1:0] != 0, performs no memory access and completes in N+1 with resp_err = 1 and resp_rdata = 0.
- When undefined: low address bits are silently truncated, and resp_err reflects only out-of-range.

Decomposition:
- Package dmem_lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding IDLE, LOAD, RMW_RD, WRITE, RESP;
  - the default RAM_SIZE constant.
- Natural sub-module: dmem_lane_align.
  - Purely combinational.
  - Load path: lane extract plus sign/zero extension.
  - Store path: byte/half merge into a 32-bit word.
  - Instantiated once, and unit-tested separately.

Test Plan:
- Memory word 0x10 = 0x8899AABB; load byte signed at 0x13 -> resp_rdata 0xFFFFFF88 in N+2. Same load unsigned -> 0x00000088.
- Store half 0x1234 at 0x12 into word 0x8899AABB -> mem_rd at N+1, mem_wr at N+2 with wdata 0x1234AABB, resp_valid at N+3.
- Word store 0xDEADBEEF at 0x20, then word load at 0x20 -> returns 0xDEADBEEF. Check req_ready is low from N+1 to N+2.
- Load at 0x400 with RAM_SIZE = 256 -> no strobe, resp_err = 1, resp_rdata = 0 in N+1.
- Assert reset during RMW_RD of a byte store to 0x30 -> mem_wr never asserted, memory word unchanged, no resp_valid, req_ready = 1 after reset deasserts.
- With DMEM_LSU_MISALIGN_TRAP_EN, word load at 0x22 -> resp_err = 1 at N+1, no mem_rd. Without the macro, the same load reads word 0x20.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: size/state encodings and defaults shared by the LSU.
// Option macro used by dmem_lsu: DMEM_LSU_MISALIGN_TRAP_EN.
package dmem_lsu_pkg;

  localparam int unsigned RAM_SIZE_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_e;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane extract/extend (load) and merge (store).
// In: size_i, sgn_i, lane_i, rdata_i, wdata_i  Out: ld_data_o, st_word_o.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    ld_data_o = rdata_i;
    st_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
        st_word_o = rdata_i;
        case (lane_i)
          2'd1:    st_word_o[15:8]  = wdata_i[7:0];
          2'd2:    st_word_o[23:16] = wdata_i[7:0];
          2'd3:    st_word_o[31:24] = wdata_i[7:0];
          default: st_word_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        ld_data_o = {{16{sgn_i & half_sel[15]}}, half_sel};
        st_word_o = lane_i[1] ? {wdata_i[15:0], rdata_i[15:0]}
                              : {rdata_i[31:16], wdata_i[15:0]};
      end
      default: begin
        ld_data_o = rdata_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator to word memory; sub-word stores via RMW.
// Ports: req_* from CPU, resp_* completion, mem_* word port. Option: DMEM_LSU_MISALIGN_TRAP_EN.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned RAM_SIZE = RAM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIM = 33'(RAM_SIZE) << 2;

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;

  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_oor;
  logic        req_mis;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  dmem_lane_align u_align (
    .size_i    (size_q),
    .sgn_i     (sgn_q),
    .lane_i    (lane_q),
    .rdata_i   (mem_rdata),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  assign req_ready = (state_q == IDLE) && !reset;
  assign req_oor   = {1'b0, req_addr} >= ADDR_LIM;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign req_mis = (req_size == SZ_HALF && req_addr[0])
                || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign req_err = req_oor | req_mis;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d    = LOAD;
            mem_rd_d   = 1'b1;
            mem_addr_d = word_addr(req_addr);
          end else if (req_size[1]) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_addr_d  = word_addr(req_addr);
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RMW_RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = word_addr(req_addr);
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      RMW_RD: begin
        // merged word lands directly in the write-data register
        state_d     = WRITE;
        mem_wr_d    = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = st_word;
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random checks of dmem_lsu against a byte-level model.
// Honours DMEM_LSU_MISALIGN_TRAP_EN when the build defines it.
module tb_dmem_lsu;

  localparam int unsigned RAM_SIZE = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [RAM_SIZE];
  logic [31:0] ref_mem [RAM_SIZE];

  int checks = 0;
  int errors = 0;

  // observations of the last transaction (cycle offsets from handshake)
  int          o_rd, o_wr, o_resp;
  int          o_rd_cnt, o_wr_cnt, o_resp_cnt;
  int          o_bad, o_ready_hi;
  logic        o_ready0, o_err;
  logic [31:0] o_rdata, o_wdata, o_waddr, o_raddr;

  // model expectations
  int          e_rd, e_wr, e_resp;
  logic        e_err, e_oor;
  logic [31:0] e_rdata, e_wword, e_addr;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] = mem_wdata;
  end

  dmem_lsu #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Byte-level reference: size in bytes, offset rounded down, mask/shift.
  task automatic model(input logic we, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wd);
    int unsigned nb, off, lim;
    logic [63:0] m;
    logic [31:0] mask, word, v;
    logic        mis;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lim = RAM_SIZE * 4;
    mis = 1'b0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    mis = (addr % nb) != 0;
`endif
    e_oor   = addr >= lim;
    e_err   = e_oor || mis;
    e_addr  = (addr / 4) * 4;
    e_rdata = '0;
    e_wword = '0;
    if (e_err) begin
      e_rd = 0; e_wr = 0; e_resp = 1;
      return;
    end
    word = ref_mem[addr / 4];
    off  = (addr % 4) / nb * nb;
    m    = (64'd1 << (8 * nb)) - 64'd1;
    mask = m[31:0];
    if (!we) begin
      v = (word >> (8 * off)) & mask;
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e_rdata = v;
      e_rd = 1; e_wr = 0; e_resp = 2;
    end else begin
      e_wword = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[addr / 4] = e_wword;
      if (nb == 4) begin
        e_rd = 0; e_wr = 1; e_resp = 2;
      end else begin
        e_rd = 1; e_wr = 2; e_resp = 3;
      end
    end
  endtask

  // Issue one request and watch cycles N+1..N+8.
  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_signed = sgn; req_addr = addr; req_wdata = wd;
    #1 o_ready0 = req_ready;
    o_rd = 0; o_wr = 0; o_resp = 0;
    o_rd_cnt = 0; o_wr_cnt = 0; o_resp_cnt = 0;
    o_bad = 0; o_ready_hi = 0; o_err = 1'b0;
    o_rdata = '0; o_wdata = '0; o_waddr = '0; o_raddr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      // garbage request during N+1 must be ignored
      req_valid = (k == 1);
      req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      #1;
      if (mem_rd) begin
        o_rd_cnt++;
        if (o_rd == 0) begin o_rd = k; o_raddr = mem_addr; end
      end
      if (mem_wr) begin
        o_wr_cnt++;
        if (o_wr == 0) begin
          o_wr = k; o_wdata = mem_wdata; o_waddr = mem_addr;
        end
      end
      if (resp_valid) begin
        o_resp_cnt++;
        if (o_resp == 0) begin
          o_resp = k; o_rdata = resp_rdata; o_err = resp_err;
        end
      end
      if (mem_rd && mem_wr) o_bad++;
      if (!mem_rd && !mem_wr && (mem_addr != 0 || mem_wdata != 0)) o_bad++;
      if ((o_resp == 0 || k <= o_resp) && req_ready) o_ready_hi++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b rd=%h err=%b mrd=%b mwr=%b ma=%h mwd=%h want all 0",
               resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_load_byte;
    poke(4, 32'h8899AABB);
    model(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    checks++;
    if (o_rdata !== 32'hFFFFFF88 || o_resp !== 2) begin
      errors++;
      $display("FAIL lb_signed: got %h@%0d want ffffff88@2", o_rdata, o_resp);
    end
    model(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    checks++;
    if (o_rdata !== 32'h00000088 || o_resp !== 2 || o_rd !== 1) begin
      errors++;
      $display("FAIL lbu: got %h resp@%0d rd@%0d want 00000088 resp@2 rd@1",
               o_rdata, o_resp, o_rd);
    end
  endtask

  task automatic test_rmw_half;
    model(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
    checks++;
    if (o_rd !== 1 || o_wr !== 2 || o_resp !== 3) begin
      errors++;
      $display("FAIL sh_latency: got rd@%0d wr@%0d resp@%0d want 1/2/3",
               o_rd, o_wr, o_resp);
    end
    checks++;
    if (o_wdata !== 32'h1234AABB || o_waddr !== 32'h10) begin
      errors++;
      $display("FAIL sh_wdata: got %h@%h want 1234aabb@00000010", o_wdata, o_waddr);
    end
    checks++;
    if (o_bad !== 0 || o_resp_err_chk()) begin
      errors++; $display("FAIL sh_hygiene: got bad=%0d err=%b want 0/0", o_bad, o_err);
    end
  endtask

  function automatic logic o_resp_err_chk();
    return o_err !== 1'b0;
  endfunction

  task automatic test_word_store_load;
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    checks++;
    if (o_wr !== 1 || o_resp !== 2 || o_rd_cnt !== 0 || o_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw: got wr@%0d resp@%0d rds=%0d wd=%h want 1/2/0/deadbeef",
               o_wr, o_resp, o_rd_cnt, o_wdata);
    end
    checks++;
    if (o_ready_hi !== 0 || o_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready: got busy_hi=%0d idle=%b want 0/1", o_ready_hi, o_ready0);
    end
    model(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    checks++;
    if (o_rdata !== 32'hDEADBEEF || o_ready_hi !== 0) begin
      errors++;
      $display("FAIL lw: got %h busy_hi=%0d want deadbeef/0", o_rdata, o_ready_hi);
    end
  endtask

  task automatic test_out_of_range;
    model(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    checks++;
    if (o_resp !== 1 || o_err !== 1'b1 || o_rdata !== 0 || o_rd_cnt + o_wr_cnt !== 0) begin
      errors++;
      $display("FAIL oor_load: got resp@%0d err=%b rd=%h strobes=%0d want 1/1/0/0",
               o_resp, o_err, o_rdata, o_rd_cnt + o_wr_cnt);
    end
    do_req(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h5A);
    checks++;
    if (o_resp !== 1 || o_err !== 1'b1 || o_wr_cnt !== 0) begin
      errors++;
      $display("FAIL oor_store: got resp@%0d err=%b wrs=%0d want 1/1/0",
               o_resp, o_err, o_wr_cnt);
    end
    poke(255, 32'hA1B2C3D4);
    model(1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
    checks++;
    if (o_rdata !== 32'hFFFFFFA1 || o_err !== 1'b0 || o_raddr !== 32'h3FC) begin
      errors++;
      $display("FAIL last_byte: got %h err=%b addr=%h want ffffffa1/0/000003fc",
               o_rdata, o_err, o_raddr);
    end
  endtask

  task automatic test_reset_abort;
    poke(12, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b1) begin
      errors++; $display("FAIL abort_rmw_rd: got %b want 1", mem_rd);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready_in_reset: got %b want 0", req_ready);
    end
    o_bad = 0;
    @(negedge clk);
    if (mem_rd || mem_wr || resp_valid) o_bad++;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready_after: got %b want 1", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_wr || resp_valid) o_bad++;
    end
    checks++;
    if (o_bad !== 0 || mem[12] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL abort_no_write: got bad=%0d word=%h want 0/cafef00d", o_bad, mem[12]);
    end
  endtask

  task automatic test_misalign;
    model(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    checks++;
    if (o_resp !== 1 || o_err !== 1'b1 || o_rd_cnt !== 0 || o_rdata !== 0) begin
      errors++;
      $display("FAIL misalign_trap: got resp@%0d err=%b rds=%0d rd=%h want 1/1/0/0",
               o_resp, o_err, o_rd_cnt, o_rdata);
    end
`else
    checks++;
    if (o_resp !== 2 || o_err !== 1'b0 || o_rdata !== 32'hDEADBEEF || o_raddr !== 32'h20) begin
      errors++;
      $display("FAIL misalign_trunc: got resp@%0d err=%b rd=%h addr=%h want 2/0/deadbeef/20",
               o_resp, o_err, o_rdata, o_raddr);
    end
`endif
  endtask

  task automatic test_random;
    logic        we, sgn;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom);
      sgn = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'h3F8 + 32'($urandom_range(0, 15));
      else addr = 32'($urandom_range(0, 63));
      model(we, sz, sgn, addr, wd);
      do_req(we, sz, sgn, addr, wd);
      checks++;
      if (o_rd !== e_rd || o_wr !== e_wr || o_resp !== e_resp || o_resp_cnt !== 1) begin
        errors++;
        $display("FAIL rnd%0d_timing: got rd@%0d wr@%0d resp@%0d x%0d want %0d/%0d/%0d x1",
                 n, o_rd, o_wr, o_resp, o_resp_cnt, e_rd, e_wr, e_resp);
      end
      checks++;
      if (o_rdata !== e_rdata || o_err !== e_err) begin
        errors++;
        $display("FAIL rnd%0d_resp: got %h err=%b want %h err=%b (we=%b sz=%0d a=%h)",
                 n, o_rdata, o_err, e_rdata, e_err, we, sz, addr);
      end
      if (e_wr != 0) begin
        checks++;
        if (o_wdata !== e_wword || o_waddr !== e_addr) begin
          errors++;
          $display("FAIL rnd%0d_wdata: got %h@%h want %h@%h",
                   n, o_wdata, o_waddr, e_wword, e_addr);
        end
      end
      checks++;
      if (o_bad !== 0 || o_ready_hi !== 0 || o_ready0 !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_port: got bad=%0d busy_hi=%0d idle=%b want 0/0/1",
                 n, o_bad, o_ready_hi, o_ready0);
      end
      if (!e_oor) begin
        checks++;
        if (mem[addr / 4] !== ref_mem[addr / 4]) begin
          errors++;
          $display("FAIL rnd%0d_mem: got %h want %h", n, mem[addr / 4], ref_mem[addr / 4]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(RAM_SIZE); i++) poke(i, $urandom);
    test_reset;
    test_load_byte;
    test_rmw_half;
    test_word_store_load;
    test_out_of_range;
    test_misalign;
    test_reset_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
